// File: rtl/r8_result_serializer_if.sv
// Handshake bundle between the radix-8 butterfly outputs and the result serializer.
// The serializer takes the slave modport; the butterfly side and the bench take the master modport.
interface r8_result_serializer_if #(
  parameter int width = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             in_select;
  logic [width-1:0] in_word_1;
  logic [width-1:0] in_word_2;
  logic [width-1:0] in_word_3;
  logic [width-1:0] in_word_4;
  logic [width-1:0] in_word_5;
  logic [width-1:0] in_word_6;
  logic [width-1:0] in_word_7;
  logic [width-1:0] in_word_8;

  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] out_data;
  logic [2:0]       out_index;
  logic             out_last;
  logic             out_stage_done;
  logic [15:0]      beat_count;

  modport master (
    output in_valid, in_select,
    output in_word_1, in_word_2, in_word_3, in_word_4,
    output in_word_5, in_word_6, in_word_7, in_word_8,
    output out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last, out_stage_done, beat_count
  );

  modport slave (
    input  in_valid, in_select,
    input  in_word_1, in_word_2, in_word_3, in_word_4,
    input  in_word_5, in_word_6, in_word_7, in_word_8,
    input  out_ready,
    output in_ready, out_valid, out_data, out_index, out_last, out_stage_done, beat_count
  );
endinterface

// File: rtl/r8_result_serializer.sv
// Two-beat buffer that turns 8-word butterfly results into a one-word-per-cycle coefficient stream.
// Optional INTT scaling by N^-1 mod Q at capture is compiled in with `define INTT_SCALE_EN.
module r8_result_serializer #(
  parameter int width           = 32,
  parameter int Q               = 12289,
  parameter int N_INV           = 12265,
  parameter int BEATS_PER_STAGE = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  r8_result_serializer_if.slave bus
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  localparam logic [15:0] LAST_BEAT = 16'(BEATS_PER_STAGE - 1);

  if (BEATS_PER_STAGE < 1 || N_INV >= Q) begin : g_param_check
    $error("r8_result_serializer: BEATS_PER_STAGE must be >= 1 and N_INV < Q");
  end

  occ_t             occ, occ_next;
  logic             wr_ptr, rd_ptr;
  logic [2:0]       out_index;
  logic [15:0]      beat_count;
  logic [width-1:0] slot_word [2][8];
  logic [width-1:0] cap_word  [8];

  logic in_ready_c, out_valid_c, capture, transfer, retire, stage_end;

`ifdef INTT_SCALE_EN
  // Full double-width product reduced mod Q before it reaches the slot register.
  function automatic logic [width-1:0] scale_word(input logic [width-1:0] w);
    logic [2*width-1:0] prod;
    prod = (2*width)'(w) * (2*width)'(N_INV);
    return width'(prod % (2*width)'(Q));
  endfunction
`endif

  always_comb begin
    cap_word[0] = bus.in_word_1;
    cap_word[1] = bus.in_word_2;
    cap_word[2] = bus.in_word_3;
    cap_word[3] = bus.in_word_4;
    cap_word[4] = bus.in_word_5;
    cap_word[5] = bus.in_word_6;
    cap_word[6] = bus.in_word_7;
    cap_word[7] = bus.in_word_8;
`ifdef INTT_SCALE_EN
    if (bus.in_select) begin
      for (int i = 0; i < 8; i++) cap_word[i] = scale_word(cap_word[i]);
    end
`endif
  end

  // NOTE: every signal driven here gets a default before any branch, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    occ_next    = occ;
    in_ready_c  = (occ != OCC_FULL);
    out_valid_c = (occ != OCC_EMPTY);
    capture     = bus.in_valid && in_ready_c;
    transfer    = out_valid_c && bus.out_ready;
    retire      = transfer && (out_index == 3'd7);
    stage_end   = retire && (beat_count == LAST_BEAT);
    case (occ)
      OCC_EMPTY: if (capture) occ_next = OCC_ONE;
      OCC_ONE: begin
        if (capture && !retire)      occ_next = OCC_FULL;
        else if (!capture && retire) occ_next = OCC_EMPTY;
      end
      OCC_FULL:  if (retire) occ_next = OCC_ONE;
      default:   occ_next = OCC_EMPTY;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ <= OCC_EMPTY;
    else        occ <= occ_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      out_index  <= 3'd0;
      beat_count <= 16'd0;
    end else begin
      if (capture) wr_ptr <= ~wr_ptr;
      if (transfer) out_index <= out_index + 3'd1;
      if (retire) begin
        rd_ptr     <= ~rd_ptr;
        beat_count <= stage_end ? 16'd0 : beat_count + 16'd1;
      end
    end
  end

  // NOTE: the slot storage has no reset; a slot is only read while occupancy says it
  // holds a captured beat, and out_data is forced to zero otherwise.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < 8; i++) slot_word[wr_ptr][i] <= cap_word[i];
    end
  end

  assign bus.in_ready       = in_ready_c;
  assign bus.out_valid      = out_valid_c;
  assign bus.out_data       = out_valid_c ? slot_word[rd_ptr][out_index] : '0;
  assign bus.out_index      = out_index;
  assign bus.out_last       = (out_index == 3'd7);
  assign bus.out_stage_done = out_valid_c && (out_index == 3'd7) && (beat_count == LAST_BEAT);
  assign bus.beat_count     = beat_count;

endmodule

// File: tb/tb_r8_result_serializer.sv
// Directed bench for r8_result_serializer with a two-beat stage; expectations are hand-derived.
// Drives inputs 1 time unit after the rising edge and samples outputs on the falling edge.
module tb_r8_result_serializer;

  localparam int BPS = 2;

  typedef struct packed {
    logic             sel;
    logic [7:0][31:0] w;
    logic [7:0][31:0] e;
  } beat_t;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  idx;
    logic        last;
    logic        done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  r8_result_serializer_if #(.width(32)) bus ();

  r8_result_serializer #(
    .width(32), .Q(12289), .N_INV(12265), .BEATS_PER_STAGE(BPS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  int    m_beats = 0;
  beat_t pend_q[$];
  exp_t  exp_q[$];
  logic  ir_hist[64];
  int    cycles;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic beat_t mk_seq(input int base, input logic sel);
    beat_t b;
    b.sel = sel;
    for (int i = 0; i < 8; i++) begin
      b.w[i] = 32'(base + i);
      b.e[i] = 32'(base + i);
    end
    return b;
  endfunction

  function automatic beat_t mk_const(input int val, input logic sel, input int expv);
    beat_t b;
    b.sel = sel;
    for (int i = 0; i < 8; i++) begin
      b.w[i] = 32'(val);
      b.e[i] = 32'(expv);
    end
    return b;
  endfunction

  task automatic drive_beat(input beat_t b);
    bus.in_select = b.sel;
    bus.in_word_1 = b.w[0]; bus.in_word_2 = b.w[1];
    bus.in_word_3 = b.w[2]; bus.in_word_4 = b.w[3];
    bus.in_word_5 = b.w[4]; bus.in_word_6 = b.w[5];
    bus.in_word_7 = b.w[6]; bus.in_word_8 = b.w[7];
  endtask

  // mode 0: out_ready always high; mode 1: out_ready follows 1,0,0,1 repeating.
  task automatic stream(input string tag, input int mode, input int budget, output int ncyc);
    int   cyc = 0;
    logic acc;
    while ((pend_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      bus.in_valid = (pend_q.size() > 0);
      if (pend_q.size() > 0) drive_beat(pend_q[0]);
      bus.out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      @(negedge clk);
      if (cyc < 64) ir_hist[cyc] = bus.in_ready;
      acc = bus.in_valid && bus.in_ready;
      check({tag, " out_valid"}, 32'(bus.out_valid), 32'(exp_q.size() > 0));
      if (bus.out_valid && exp_q.size() > 0) begin
        check({tag, " out_data"},  bus.out_data,              exp_q[0].data);
        check({tag, " out_index"}, 32'(bus.out_index),        32'(exp_q[0].idx));
        check({tag, " out_last"},  32'(bus.out_last),         32'(exp_q[0].last));
        check({tag, " stage_done"}, 32'(bus.out_stage_done),  32'(exp_q[0].done));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
      if (acc) begin
        for (int i = 0; i < 8; i++) begin
          exp_t x;
          x.data = pend_q[0].e[i];
          x.idx  = 3'(i);
          x.last = (i == 7);
          x.done = (i == 7) && (m_beats % BPS == BPS - 1);
          exp_q.push_back(x);
        end
        void'(pend_q.pop_front());
        m_beats++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    check({tag, " drained"}, 32'(pend_q.size() + exp_q.size()), 32'd0);
    ncyc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_beat(mk_seq(0, 1'b0));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst out_valid",  32'(bus.out_valid),      32'd0);
    check("rst in_ready",   32'(bus.in_ready),       32'd1);
    check("rst beat_count", 32'(bus.beat_count),     32'd0);
    check("rst out_data",   bus.out_data,            32'd0);
    check("rst out_last",   32'(bus.out_last),       32'd0);
    check("rst stage_done", 32'(bus.out_stage_done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single beat 1..8, then a second beat closing the two-beat stage
    pend_q.push_back(mk_seq(1, 1'b0));
    stream("t1", 0, 40, cycles);
    check("t1 cycles", 32'(cycles), 32'd9);
    check("t1 beat_count", 32'(bus.beat_count), 32'd1);
    pend_q.push_back(mk_seq(11, 1'b0));
    stream("t4", 0, 40, cycles);
    check("t4 beat_count wrap", 32'(bus.beat_count), 32'd0);

    // Three back-to-back beats: backpressure window and gap-free output
    pend_q.push_back(mk_seq(21, 1'b0));
    pend_q.push_back(mk_seq(31, 1'b0));
    pend_q.push_back(mk_seq(41, 1'b0));
    stream("t2", 0, 80, cycles);
    check("t2 cycles", 32'(cycles), 32'd25);
    for (int c = 0; c < 10; c++)
      check($sformatf("t2 in_ready c%0d", c), 32'(ir_hist[c]), 32'((c < 2) || (c == 9)));
    check("t2 beat_count", 32'(bus.beat_count), 32'd1);

    // Stalled output: 1,0,0,1 ready pattern
    pend_q.push_back(mk_seq(51, 1'b0));
    stream("t3", 1, 60, cycles);
    check("t3 cycles", 32'(cycles), 32'd17);
    check("t3 beat_count", 32'(bus.beat_count), 32'd0);

    // INTT scaling: 512 * N^-1 mod Q = 1 when compiled in
`ifdef INTT_SCALE_EN
    pend_q.push_back(mk_const(512, 1'b1, 1));
`else
    pend_q.push_back(mk_const(512, 1'b1, 512));
`endif
    pend_q.push_back(mk_const(512, 1'b0, 512));
    stream("t5", 0, 60, cycles);
    check("t5 beat_count", 32'(bus.beat_count), 32'd0);

    // Reset in the middle of a beat
    pend_q.push_back(mk_seq(91, 1'b0));
    stream("t6a", 0, 40, cycles);
    check("t6 pre beat_count", 32'(bus.beat_count), 32'd1);
    drive_beat(mk_seq(101, 1'b0));
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("t6 mid out_index", 32'(bus.out_index), 32'd3);
    check("t6 mid out_data",  bus.out_data,       32'd104);
    #2 rst_n = 1'b0;
    #1;
    check("t6 rst out_valid",  32'(bus.out_valid),  32'd0);
    check("t6 rst in_ready",   32'(bus.in_ready),   32'd1);
    check("t6 rst beat_count", 32'(bus.beat_count), 32'd0);
    check("t6 rst out_index",  32'(bus.out_index),  32'd0);
    check("t6 rst out_data",   bus.out_data,        32'd0);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    m_beats = 0;
    @(posedge clk); #1;
    pend_q.push_back(mk_seq(201, 1'b0));
    stream("t6b", 0, 40, cycles);
    check("t6b cycles", 32'(cycles), 32'd9);
    check("t6b beat_count", 32'(bus.beat_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/r8_result_serializer.md
Name: r8_result_serializer

Overview:
- Receiving end of the radix-8 butterfly core's output interface.
- Captures one 8-word parallel result beat (output_1..output_8) per handshake and buffers up to 2 beats.
- Streams the words out one per cycle toward coefficient memory, with optional INTT scaling by N^-1 mod Q.
- Flags the final word of a stage so the stage controller can advance.

Parameters:
- width, 32, coefficient word width (matches parameter.vh).
- Q, 12289, modulus; all stored words are < Q.
- N_INV, 12265, N^-1 mod Q (N=512); used only with scaling compiled in.
- BEATS_PER_STAGE, 64, 8-word beats per NTT stage; must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  parallel beat present.
- in_ready  out  1  serializer can accept a beat.
- in_select  in  1  0=NTT, 1=INTT; sampled with the beat.
- in_word_1..in_word_8  in  width each  butterfly outputs 1..8.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts word.
- out_data  out  width  serialized coefficient.
- out_index  out  3  word position within beat (0 = in_word_1).
- out_last  out  1  high on index 7.
- out_stage_done  out  1  high with the final word of the final beat of a stage.
- beat_count  out  16  beats fully emitted in current stage.

Behaviour:
- Reset (async assert, sync release): buffer empty, wr_ptr=rd_ptr=0, out_index=0, beat_count=0, out_valid=0, in_ready=1, out_data=0, out_last=0, out_stage_done=0.
- Buffer:
  - 2 slots of 8 words plus a select bit; occupancy count 0..2.
  - in_ready = (count<2); combinational from registered state, not dependent on in_valid.
  - Capture on in_valid&&in_ready at the clk edge: writes slot wr_ptr, toggles wr_ptr, count+1.
- Output:
  - out_valid = (count>0).
  - out_data = slot[rd_ptr].word[out_index]; out_last = (out_index==7).
  - Transfer on out_valid&&out_ready: out_index+1.
  - When out_index==7 at transfer: out_index→0, rd_ptr toggles, count-1, beat_count+1.
- Simultaneous capture and beat retirement in one cycle: count unchanged; both pointers advance.
- Retirement frees the slot only after the edge, so a full buffer re-asserts in_ready the cycle after word 7 transfers.
- Latency: beat captured at edge k → word 0 presented at cycle k+1 if the buffer was empty. Throughput 8 words per 8 cycles sustained, no bubbles.
- out_ready low: out_data, out_index, out_last held stable; out_valid stays high.
- Stage end:
  - out_stage_done = out_last && (beat_count==BEATS_PER_STAGE-1); combinational, qualified by out_valid.
  - On that transfer beat_count wraps to 0.
- in_valid while full: beat not captured, no data loss; upstream must hold the beat.
- Inputs ≥ Q are passed unmodified (no reduction) when scaling is compiled out.
- rst_n asserted mid-beat: partial beat discarded, all state returns to reset values immediately.

Optional Feature:
- Macro INTT_SCALE_EN.
- Defined: at capture, each word of a beat with in_select=1 is stored as (word*N_INV) mod Q.
  - Full 2*width product, reduced combinationally before the register.
  - Latency unchanged. in_select=0 beats stored unmodified.
- Undefined: all words stored unmodified regardless of in_select; the N_INV parameter is ignored.

Test Plan:
- Reset then one beat with words 1..8, out_ready=1 → out_data 1,2,…,8 on 8 consecutive cycles starting 1 cycle after capture; out_last only on 8; beat_count 0→1.
- Three back-to-back beats, out_ready=1 → in_ready low from the cycle after beat 2 captured until beat 1 word 7 transfers, then high next cycle; 24 words in order, no gaps.
- out_ready toggled 1,0,0,1 repeating → out_data/out_index stable while stalled; all 8 words appear once in order.
- BEATS_PER_STAGE=2, stream 2 beats → out_stage_done high only with word 8 of beat 2; beat_count returns to 0.
- INTT_SCALE_EN defined, in_select=1, words all 512 → every out_data = 1; in_select=0, word 512 → 512.
- rst_n pulsed low after 3 words of a beat → out_valid=0, in_ready=1, beat_count=0 immediately; next beat emits from index 0.
